// File: rtl/apg_pkg.sv
// Shared types for the pattern sequencer: FSM state encoding and sticky error bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } apg_state_t;

    localparam int ERR_WR_BUSY  = 0;
    localparam int ERR_WR_RANGE = 1;
    localparam int ERR_ABORT    = 2;

endpackage

// File: rtl/apg_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Latency: read data 1 cycle after raddr; write visible on the following read.
// Backpressure: none, accepts a write and a read every cycle.
module apg_sdp_ram #(
    parameter int W     = 14,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/arb_pattern_sequencer.sv
// Arbitrary pattern generator: plays pattern memory onto output_signals and captures input_signals.
// Latency: output_signals shows pattern[0] 1 cycle after start (or after ext_trig when armed).
// Backpressure: none; illegal writes are dropped and flagged in err.
module arb_pattern_sequencer
    import apg_pkg::*;
#(
    parameter int NUM_SIG  = 14,
    parameter int NUM_SAMP = 256,
    parameter int CNT_W    = 16
) (
    input  logic                        wave_clk,
    input  logic                        wave_reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        trig_mode,
    input  logic                        ext_trig,
    input  logic [31:0]                 n_samples,
    input  logic [CNT_W-1:0]            hold_div,
    input  logic [CNT_W-1:0]            loop_count,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_SAMP)-1:0] wr_addr,
    input  logic [NUM_SIG-1:0]          wr_data,
    input  logic [$clog2(NUM_SAMP)-1:0] rd_addr,
    output logic [NUM_SIG-1:0]          rd_data,
    output logic [NUM_SIG-1:0]          output_signals,
    input  logic [NUM_SIG-1:0]          input_signals,
    output logic [1:0]                  state_o,
    output logic [31:0]                 sample_count,
    output logic [CNT_W-1:0]            pass_count,
    output logic                        done_pulse,
    output logic [2:0]                  err,
    input  logic                        err_clear
);

    localparam int           AW      = $clog2(NUM_SAMP);
    localparam logic [31:0]  DEPTH32 = 32'(NUM_SAMP);
    localparam logic [AW:0]  DEPTH_L = (AW + 1)'(NUM_SAMP);

    apg_state_t        state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     ptr_nxt;
    logic [AW-1:0]     pat_raddr;
    logic [CNT_W-1:0]  hold_cnt;
    logic [NUM_SIG-1:0] pat_q;
    logic [31:0]       eff_len;
    logic              sample_end;
    logic              pass_end;
    logic              run_done;
    logic              abort_hit;
    logic              wr_busy;
    logic              wr_range;
    logic              pat_we;
    logic              cap_we;
    logic [2:0]        err_evt;

    always_comb begin
        if (n_samples == 32'd0) begin
            eff_len = 32'd1;
        end else if (n_samples > DEPTH32) begin
            eff_len = DEPTH32;
        end else begin
            eff_len = n_samples;
        end
    end

    assign sample_end = (state == ST_RUN) && (hold_cnt == hold_div);
    assign pass_end   = sample_end && ({{(32-AW){1'b0}}, ptr} == eff_len - 32'd1);
    assign run_done   = pass_end && (loop_count != '0) && (pass_count + CNT_W'(1) == loop_count);
    assign abort_hit  = abort && ((state == ST_ARMED) || (state == ST_RUN));

    always_comb begin
        ptr_nxt = ptr;
        if (sample_end) begin
            ptr_nxt = pass_end ? '0 : ptr + AW'(1);
        end
    end

    // Outside RUN the read address parks on 0 so pattern[0] is already on the
    // RAM output register in the cycle RUN is entered.
    assign pat_raddr = (state == ST_RUN) ? ptr_nxt : '0;

    assign wr_busy  = wr_en && (state != ST_IDLE);
    assign wr_range = wr_en && ({1'b0, wr_addr} >= DEPTH_L);
    assign pat_we   = wr_en && (state == ST_IDLE) && !wr_range;
    assign cap_we   = sample_end && !abort;

    always_comb begin
        err_evt               = '0;
        err_evt[ERR_WR_BUSY]  = wr_busy;
        err_evt[ERR_WR_RANGE] = wr_range;
        err_evt[ERR_ABORT]    = abort_hit;
    end

    apg_sdp_ram #(.W(NUM_SIG), .DEPTH(NUM_SAMP), .AW(AW)) u_pat_ram (
        .clk   (wave_clk),
        .rst   (wave_reset),
        .we    (pat_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pat_raddr),
        .rdata (pat_q)
    );

    apg_sdp_ram #(.W(NUM_SIG), .DEPTH(NUM_SAMP), .AW(AW)) u_cap_ram (
        .clk   (wave_clk),
        .rst   (wave_reset),
        .we    (cap_we),
        .waddr (ptr),
        .wdata (input_signals),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge wave_clk or posedge wave_reset) begin
        if (wave_reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            sample_count <= '0;
            pass_count   <= '0;
            done_pulse   <= 1'b0;
            err          <= '0;
        end else begin
            done_pulse <= 1'b0;
            // A new error event beats a same-cycle clear.
            err        <= (err_clear ? 3'b000 : err) | err_evt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= trig_mode ? ST_ARMED : ST_RUN;
                        ptr          <= '0;
                        hold_cnt     <= '0;
                        sample_count <= '0;
                        pass_count   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (ext_trig) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (sample_end) begin
                        hold_cnt     <= '0;
                        sample_count <= sample_count + 32'd1;
                        ptr          <= ptr_nxt;
                        if (pass_end) begin
                            pass_count <= pass_count + CNT_W'(1);
                        end
                        if (run_done) begin
                            state      <= ST_DONE;
                            done_pulse <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by the async-reset state register, so reset clears the pins at once.
    assign output_signals = (state == ST_RUN) ? pat_q : '0;
    assign state_o        = state;

endmodule

// File: tb/tb_arb_pattern_sequencer.sv
// Directed bench for arb_pattern_sequencer with NUM_SAMP=8 and a pattern of k at address k.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_arb_pattern_sequencer;

    localparam int NUM_SIG  = 14;
    localparam int NUM_SAMP = 8;
    localparam int CNT_W    = 16;

    logic               wave_clk;
    logic               wave_reset;
    logic               start;
    logic               abort;
    logic               trig_mode;
    logic               ext_trig;
    logic [31:0]        n_samples;
    logic [CNT_W-1:0]   hold_div;
    logic [CNT_W-1:0]   loop_count;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [NUM_SIG-1:0] wr_data;
    logic [2:0]         rd_addr;
    logic [NUM_SIG-1:0] rd_data;
    logic [NUM_SIG-1:0] output_signals;
    logic [NUM_SIG-1:0] input_signals;
    logic [1:0]         state_o;
    logic [31:0]        sample_count;
    logic [CNT_W-1:0]   pass_count;
    logic               done_pulse;
    logic [2:0]         err;
    logic               err_clear;

    int vectors;
    int miscompares;

    arb_pattern_sequencer #(
        .NUM_SIG (NUM_SIG),
        .NUM_SAMP(NUM_SAMP),
        .CNT_W   (CNT_W)
    ) dut (
        .wave_clk      (wave_clk),
        .wave_reset    (wave_reset),
        .start         (start),
        .abort         (abort),
        .trig_mode     (trig_mode),
        .ext_trig      (ext_trig),
        .n_samples     (n_samples),
        .hold_div      (hold_div),
        .loop_count    (loop_count),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .output_signals(output_signals),
        .input_signals (input_signals),
        .state_o       (state_o),
        .sample_count  (sample_count),
        .pass_count    (pass_count),
        .done_pulse    (done_pulse),
        .err           (err),
        .err_clear     (err_clear)
    );

    // Pattern[k] = k, so the driven value is the pointer and this is ptr + 0x10.
    assign input_signals = output_signals + 14'h10;

    initial wave_clk = 1'b0;
    always #5 wave_clk = ~wave_clk;

    task automatic tick();
        @(posedge wave_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;
        vectors     = 0;
        miscompares = 0;
        wave_reset  = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        trig_mode   = 1'b0;
        ext_trig    = 1'b0;
        n_samples   = 32'd4;
        hold_div    = '0;
        loop_count  = 16'd1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_addr     = '0;
        err_clear   = 1'b0;

        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_out", 32'(output_signals), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_samples", sample_count, 32'd0);
        chk("rst_passes", 32'(pass_count), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        wave_reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(k);
            wr_data = 14'(k);
            tick();
        end
        wr_en = 1'b0;
        chk("load_err", 32'(err), 32'd0);

        // Single pass of 4 samples, no hold.
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            chk("p1_out", 32'(output_signals), 32'(i));
            chk("p1_state", 32'(state_o), 32'd2);
        end
        tick();
        chk("p1_done", 32'(done_pulse), 32'd1);
        chk("p1_done_state", 32'(state_o), 32'd3);
        chk("p1_done_out", 32'(output_signals), 32'd0);
        chk("p1_samples", sample_count, 32'd4);
        chk("p1_passes", 32'(pass_count), 32'd1);
        tick();
        chk("p1_idle_done", 32'(done_pulse), 32'd0);
        chk("p1_idle_state", 32'(state_o), 32'd0);
        chk("p1_idle_out", 32'(output_signals), 32'd0);

        // Hold of 3 cycles, 2 samples, 2 passes.
        n_samples  = 32'd2;
        hold_div   = 16'd2;
        loop_count = 16'd2;
        start      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            start = 1'b0;
            chk("hold_out", 32'(output_signals), 32'((i / 3) % 2));
        end
        tick();
        chk("hold_done", 32'(done_pulse), 32'd1);
        chk("hold_samples", sample_count, 32'd4);
        chk("hold_passes", 32'(pass_count), 32'd2);
        tick();

        // Triggered start: 10 armed cycles, then RUN after the trigger.
        hold_div   = '0;
        loop_count = 16'd1;
        trig_mode  = 1'b1;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            chk("armed_state", 32'(state_o), 32'd1);
            chk("armed_out", 32'(output_signals), 32'd0);
        end
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        chk("trig_state", 32'(state_o), 32'd2);
        chk("trig_out0", 32'(output_signals), 32'd0);
        tick();
        chk("trig_out1", 32'(output_signals), 32'd1);
        tick();
        chk("trig_done", 32'(done_pulse), 32'd1);
        trig_mode = 1'b0;
        tick();

        // n_samples = 0 behaves as a single sample per pass.
        n_samples  = 32'd0;
        loop_count = 16'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("n0_state", 32'(state_o), 32'd2);
        chk("n0_out", 32'(output_signals), 32'd0);
        tick();
        chk("n0_done", 32'(done_pulse), 32'd1);
        chk("n0_samples", sample_count, 32'd2);
        tick();

        // Infinite run, aborted after 20 cycles.
        n_samples  = 32'd4;
        loop_count = '0;
        start      = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            start = 1'b0;
            if (done_pulse) seen = 1'b1;
        end
        chk("inf_state", 32'(state_o), 32'd2);
        chk("inf_samples", sample_count, 32'd19);
        chk("inf_passes", 32'(pass_count), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (done_pulse) seen = 1'b1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_err", 32'(err), 32'h4);
        chk("abort_out", 32'(output_signals), 32'd0);
        chk("abort_no_done", 32'(seen), 32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clear_err", 32'(err), 32'd0);

        // Write while busy is dropped; the error beats a same-cycle clear.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        wr_data   = 14'h3fff;
        err_clear = 1'b1;
        tick();
        wr_en     = 1'b0;
        err_clear = 1'b0;
        chk("busy_err", 32'(err), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("busy_abort_err", 32'(err), 32'h5);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Loopback capture over a full 8-sample pass, hold of 2 cycles.
        n_samples  = 32'd8;
        hold_div   = 16'd1;
        loop_count = 16'd1;
        start      = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            start = 1'b0;
            if (done_pulse) seen = 1'b1;
        end
        chk("loop_done_seen", 32'(seen), 32'd1);
        chk("loop_samples", sample_count, 32'd8);
        tick();
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            tick();
            chk("cap_rd", 32'(rd_data), 32'(k + 16));
        end

        // Asynchronous reset in the middle of an infinite run.
        loop_count = '0;
        start      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
        end
        chk("pre_rst_out", 32'(output_signals), 32'd2);
        #2;
        wave_reset = 1'b1;
        #1;
        chk("mid_rst_out", 32'(output_signals), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_samples", sample_count, 32'd0);
        chk("mid_rst_rd", 32'(rd_data), 32'd0);
        tick();
        wave_reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
